// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared types for the 68000 bus controller: address regions, region base bytes and FSM states.
// Holds the address-decode helpers used by the controller.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    RGN_ROM     = 3'd0,
    RGN_RAM     = 3'd1,
    RGN_TICKS   = 3'd2,
    RGN_CRTC    = 3'd3,
    RGN_TILEMAP = 3'd4,
    RGN_PAL     = 3'd5,
    RGN_NONE    = 3'd6
  } region_e;

  localparam logic [7:0] BASE_ROM     = 8'h00;
  localparam logic [7:0] BASE_RAM     = 8'h10;
  localparam logic [7:0] BASE_TICKS   = 8'h20;
  localparam logic [7:0] BASE_CRTC    = 8'h80;
  localparam logic [7:0] BASE_TILEMAP = 8'h90;
  localparam logic [7:0] BASE_PAL     = 8'h91;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int         CNT_W   = 16;
  localparam logic [2:0] FC_IACK = 3'b111;

  function automatic region_e decode_region(input logic [7:0] hi);
    region_e r;
    case (hi)
      BASE_ROM:     r = RGN_ROM;
      BASE_RAM:     r = RGN_RAM;
      BASE_TICKS:   r = RGN_TICKS;
      BASE_CRTC:    r = RGN_CRTC;
      BASE_TILEMAP: r = RGN_TILEMAP;
      BASE_PAL:     r = RGN_PAL;
      default:      r = RGN_NONE;
    endcase
    return r;
  endfunction

  // bit order of sel is {PAL, TILEMAP, CRTC, TICKS, RAM, ROM}, matching the enum values
  function automatic logic [5:0] region_sel(input region_e r);
    return (r == RGN_NONE) ? 6'b000000 : (6'b000001 << r);
  endfunction

endpackage

// File: rtl/cpu_bus_ctrl_irq_prio.sv
// Interrupt edge detection, pending flags and priority encoding to the CPU's IPL lines.
// A same-cycle rising edge beats an acknowledge clear on the same source.
module irq_prio
  import cpu_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] irq_src_i,
  input  logic       ack_i,
  input  logic [2:0] ack_lvl_i,
  output logic [2:0] ipl_n_o
);

  logic [2:0] hist_q;
  logic [2:0] pend_q, pend_d;
  logic [2:0] ipl_n_q, ipl_n_d;
  logic [2:0] rise;
  logic [2:0] clr;

  assign rise = irq_src_i & ~hist_q;

  always_comb begin
    clr = 3'b000;
    if (ack_i) begin
      case (ack_lvl_i)
        3'd1:    clr = 3'b001;
        3'd2:    clr = 3'b010;
        3'd3:    clr = 3'b100;
        default: clr = 3'b000;
      endcase
    end
    pend_d = (pend_q & ~clr) | rise;
    if (pend_d[2])      ipl_n_d = 3'b100;
    else if (pend_d[1]) ipl_n_d = 3'b101;
    else if (pend_d[0]) ipl_n_d = 3'b110;
    else                ipl_n_d = 3'b111;
  end

  // history resets high so sources already asserted at reset release are ignored
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q  <= 3'b111;
      pend_q  <= 3'b000;
      ipl_n_q <= 3'b111;
    end else begin
      hist_q  <= irq_src_i;
      pend_q  <= pend_d;
      ipl_n_q <= ipl_n_d;
    end
  end

  assign ipl_n_o = ipl_n_q;

endmodule

// File: rtl/cpu_bus_ctrl.sv
// 68000 bus controller: region decode, wait-state insertion, DTACK/VPA/BERR termination
// and byte write strobes, plus interrupt priority encoding via irq_prio.
//
// state | meaning
// IDLE  | waiting for address/data strobe
// WAIT  | counting down wait states (or bus-error timeout)
// ACK   | first cycle of termination; write strobe pulses here
// HOLD  | termination held until the CPU drops AS
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int WAIT_ROM = 1,
  parameter int WAIT_RAM = 0,
  parameter int WAIT_IO  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        as_n,
  input  logic        rw,
  input  logic [1:0]  ds_n,
  input  logic [2:0]  fc,
  input  logic [23:0] addr,
  input  logic [2:0]  irq_src,
  output logic [5:0]  sel,
  output logic [1:0]  wr_stb,
  output logic        dtack_n,
  output logic        vpa_n,
  output logic        berr_n,
  output logic [2:0]  ipl_n
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wait_ld;
  logic             mapped_q, mapped_d;
  logic             write_q, write_d;
  logic [1:0]       strb_q, strb_d;
  logic [5:0]       sel_q, sel_d;
  logic [1:0]       wr_stb_q, wr_stb_d;
  logic             dtack_q, dtack_d, vpa_q, vpa_d, berr_q, berr_d;
  region_e          rgn;
  logic             iack_start, strobe, iack_ack;
  logic             unused_addr;

  assign rgn         = decode_region(addr[23:16]);
  assign iack_start  = !as_n && (fc == FC_IACK);
  assign strobe      = !as_n && (ds_n != 2'b11);
  assign unused_addr = ^{addr[15:4], addr[0]};

  always_comb begin
    case (rgn)
      RGN_ROM:  wait_ld = CNT_W'(WAIT_ROM);
      RGN_RAM:  wait_ld = CNT_W'(WAIT_RAM);
      RGN_NONE: wait_ld = CNT_W'(TIMEOUT);
      default:  wait_ld = CNT_W'(WAIT_IO);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mapped_d = mapped_q;
    write_d  = write_q;
    strb_d   = strb_q;
    case (state_q)
      ST_IDLE: begin
        if (iack_start) begin
          state_d = ST_ACK;
        end else if (strobe) begin
          state_d  = ST_WAIT;
          cnt_d    = wait_ld;
          mapped_d = (rgn != RGN_NONE);
          write_d  = !rw;
          strb_d   = ~ds_n;
        end
      end
      ST_WAIT: begin
        if (as_n)                state_d = ST_IDLE;
        else if (cnt_q == '0)    state_d = ST_ACK;
        else                     cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ACK:  state_d = as_n ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (as_n) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d    = sel_q;
    dtack_d  = dtack_q;
    vpa_d    = vpa_q;
    berr_d   = berr_q;
    wr_stb_d = 2'b00;
    if (state_d == ST_IDLE) begin
      sel_d   = 6'b000000;
      dtack_d = 1'b1;
      vpa_d   = 1'b1;
      berr_d  = 1'b1;
    end else if (state_q == ST_IDLE && state_d == ST_WAIT) begin
      sel_d = region_sel(rgn);
    end else if (state_q == ST_IDLE && state_d == ST_ACK) begin
      sel_d = 6'b000000;
      vpa_d = 1'b0;
    end else if (state_q == ST_WAIT && state_d == ST_ACK) begin
      if (mapped_q) begin
        dtack_d  = 1'b0;
        wr_stb_d = write_q ? strb_q : 2'b00;
      end else begin
        berr_d = 1'b0;
      end
    end
  end

  assign iack_ack = (state_q == ST_IDLE) && (state_d == ST_ACK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mapped_q <= 1'b0;
      write_q  <= 1'b0;
      strb_q   <= 2'b00;
      sel_q    <= 6'b000000;
      wr_stb_q <= 2'b00;
      dtack_q  <= 1'b1;
      vpa_q    <= 1'b1;
      berr_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mapped_q <= mapped_d;
      write_q  <= write_d;
      strb_q   <= strb_d;
      sel_q    <= sel_d;
      wr_stb_q <= wr_stb_d;
      dtack_q  <= dtack_d;
      vpa_q    <= vpa_d;
      berr_q   <= berr_d;
    end
  end

  irq_prio u_irq_prio (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_src_i (irq_src),
    .ack_i     (iack_ack),
    .ack_lvl_i (addr[3:1]),
    .ipl_n_o   (ipl_n)
  );

  assign sel     = sel_q;
  assign wr_stb  = wr_stb_q;
  assign dtack_n = dtack_q;
  assign vpa_n   = vpa_q;
  assign berr_n  = berr_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl: a deadline-based bus/interrupt model checked every cycle,
// plus hand-computed literal expectations at the interesting cycles.
module tb_cpu_bus_ctrl;

  localparam int W_ROM = 1;
  localparam int W_RAM = 0;
  localparam int W_IO  = 2;
  localparam int W_TO  = 255;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        as_n = 1'b1;
  logic        rw = 1'b1;
  logic [1:0]  ds_n = 2'b11;
  logic [2:0]  fc = 3'b101;
  logic [23:0] addr = 24'h0;
  logic [2:0]  irq_src = 3'b000;
  logic [5:0]  sel;
  logic [1:0]  wr_stb;
  logic        dtack_n, vpa_n, berr_n;
  logic [2:0]  ipl_n;

  int total = 0;
  int bad   = 0;

  cpu_bus_ctrl #(
    .WAIT_ROM (W_ROM),
    .WAIT_RAM (W_RAM),
    .WAIT_IO  (W_IO),
    .TIMEOUT  (W_TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .as_n    (as_n),
    .rw      (rw),
    .ds_n    (ds_n),
    .fc      (fc),
    .addr    (addr),
    .irq_src (irq_src),
    .sel     (sel),
    .wr_stb  (wr_stb),
    .dtack_n (dtack_n),
    .vpa_n   (vpa_n),
    .berr_n  (berr_n),
    .ipl_n   (ipl_n)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // region index 0..5 in sel bit order, -1 when unmapped
  function automatic int region_of(input logic [7:0] hi);
    case (hi)
      8'h00:   return 0;
      8'h10:   return 1;
      8'h20:   return 2;
      8'h80:   return 3;
      8'h90:   return 4;
      8'h91:   return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int waits_of(input int r);
    if (r < 0)  return W_TO;
    if (r == 0) return W_ROM;
    if (r == 1) return W_RAM;
    return W_IO;
  endfunction

  // model state: absolute-cycle deadline for termination instead of a counter
  bit         m_valid = 1'b0;
  int         cyc = 0;
  bit         busy = 1'b0, acked = 1'b0, m_mapped = 1'b0, m_write = 1'b0;
  int         ack_at = 0;
  int         r, lvl;
  logic [1:0] m_strb = 2'b00;
  logic [5:0] e_sel = 6'b0;
  logic [1:0] e_wr = 2'b00;
  logic       e_dtack = 1'b1, e_vpa = 1'b1, e_berr = 1'b1;
  logic [2:0] pend = 3'b000, prev = 3'b111, clr, rise;
  logic [2:0] e_ipl = 3'b111;

  initial forever begin
    @(posedge clk);
    cyc++;
    e_wr = 2'b00;
    clr  = 3'b000;
    if (!reset_n) begin
      busy = 1'b0; acked = 1'b0;
      e_sel = 6'b0; e_dtack = 1'b1; e_vpa = 1'b1; e_berr = 1'b1;
      pend = 3'b000; prev = 3'b111; e_ipl = 3'b111;
      m_valid = 1'b1;
    end else begin
      if (busy && as_n) begin
        busy = 1'b0; acked = 1'b0;
        e_sel = 6'b0; e_dtack = 1'b1; e_vpa = 1'b1; e_berr = 1'b1;
      end else if (busy && !acked && cyc == ack_at) begin
        acked = 1'b1;
        if (m_mapped) begin
          e_dtack = 1'b0;
          if (m_write) e_wr = m_strb;
        end else begin
          e_berr = 1'b0;
        end
      end else if (!busy && !as_n) begin
        if (fc == 3'b111) begin
          busy = 1'b1; acked = 1'b1;
          e_vpa = 1'b0; e_sel = 6'b0;
          lvl = int'(addr[3:1]);
          if (lvl >= 1 && lvl <= 3) clr[lvl-1] = 1'b1;
        end else if (ds_n != 2'b11) begin
          busy = 1'b1; acked = 1'b0;
          r = region_of(addr[23:16]);
          ack_at   = cyc + waits_of(r) + 1;
          m_mapped = (r >= 0);
          m_write  = !rw;
          m_strb   = ~ds_n;
          e_sel    = (r >= 0) ? 6'(1 << r) : 6'b0;
        end
      end
      rise = irq_src & ~prev;
      pend = (pend & ~clr) | rise;
      prev = irq_src;
      lvl = 0;
      for (int i = 0; i < 3; i++) if (pend[i]) lvl = i + 1;
      e_ipl = 3'(7 - lvl);
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("sel", 32'(sel), 32'(e_sel));
      check("wr_stb", 32'(wr_stb), 32'(e_wr));
      check("dtack_n", 32'(dtack_n), 32'(e_dtack));
      check("vpa_n", 32'(vpa_n), 32'(e_vpa));
      check("berr_n", 32'(berr_n), 32'(e_berr));
      check("ipl_n", 32'(ipl_n), 32'(e_ipl));
    end
  end

  task automatic start(input logic [23:0] a, input logic r_w, input logic [1:0] ds);
    addr = a; rw = r_w; ds_n = ds; fc = 3'b101; as_n = 1'b0;
  endtask

  task automatic release_bus();
    as_n = 1'b1; ds_n = 2'b11; rw = 1'b1; fc = 3'b101;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_dtack", 32'(dtack_n), 32'h1);
    check("rst_berr", 32'(berr_n), 32'h1);
    check("rst_ipl", 32'(ipl_n), 32'h7);
    reset_n = 1'b1;
    @(negedge clk);

    // ROM read, one wait state
    start(24'h000100, 1'b1, 2'b00);
    @(negedge clk); check("rom_sel", 32'(sel), 32'h01); check("rom_dt0", 32'(dtack_n), 32'h1);
    @(negedge clk); check("rom_dt1", 32'(dtack_n), 32'h1);
    @(negedge clk); check("rom_dt2", 32'(dtack_n), 32'h0);
    release_bus();
    @(negedge clk); check("rom_rel", 32'(dtack_n), 32'h1); check("rom_sel_rel", 32'(sel), 32'h0);
    @(negedge clk);

    // RAM word write, zero wait
    start(24'h100010, 1'b0, 2'b00);
    @(negedge clk); check("ram_dt0", 32'(dtack_n), 32'h1); check("ram_wr0", 32'(wr_stb), 32'h0);
    @(negedge clk); check("ram_dt1", 32'(dtack_n), 32'h0); check("ram_wr1", 32'(wr_stb), 32'h3);
    @(negedge clk); check("ram_wr2", 32'(wr_stb), 32'h0);
    release_bus();
    repeat (2) @(negedge clk);

    // unmapped read times out into a bus error
    start(24'h400000, 1'b1, 2'b00);
    repeat (256) @(negedge clk);
    check("to_berr255", 32'(berr_n), 32'h1);
    @(negedge clk);
    check("to_berr256", 32'(berr_n), 32'h0); check("to_dtack", 32'(dtack_n), 32'h1);
    release_bus();
    repeat (2) @(negedge clk);

    // interrupt priority and IACK
    irq_src = 3'b001;
    @(negedge clk); check("irq0", 32'(ipl_n), 32'h6);
    irq_src = 3'b000;
    @(negedge clk);
    irq_src = 3'b100;
    @(negedge clk); check("irq2", 32'(ipl_n), 32'h4);
    irq_src = 3'b000;
    @(negedge clk);
    addr = 24'hFFFFF6; fc = 3'b111; ds_n = 2'b00; rw = 1'b1; as_n = 1'b0;
    @(negedge clk); check("iack_vpa", 32'(vpa_n), 32'h0); check("iack_ipl", 32'(ipl_n), 32'h6);
    release_bus();
    @(negedge clk); check("iack_vpa_rel", 32'(vpa_n), 32'h1);

    // acknowledge of level 1 in the same cycle as a new level-1 edge: set wins
    addr = 24'hFFFFF2; fc = 3'b111; ds_n = 2'b00; as_n = 1'b0; irq_src = 3'b001;
    @(negedge clk); check("setwin_ipl", 32'(ipl_n), 32'h6);
    release_bus(); irq_src = 3'b000;
    @(negedge clk);
    addr = 24'hFFFFF2; fc = 3'b111; ds_n = 2'b00; as_n = 1'b0;
    @(negedge clk); check("iack1_clear", 32'(ipl_n), 32'h7);
    release_bus();
    @(negedge clk);

    // PAL write aborted during WAIT
    start(24'h910000, 1'b0, 2'b01);
    @(negedge clk); check("pal_sel", 32'(sel), 32'h20);
    release_bus();
    @(negedge clk); check("pal_sel_abort", 32'(sel), 32'h0); check("pal_dt", 32'(dtack_n), 32'h1);
    repeat (4) @(negedge clk);

    // TICKS lower-byte write, two waits
    start(24'h200004, 1'b0, 2'b10);
    repeat (3) @(negedge clk);
    check("tk_dt2", 32'(dtack_n), 32'h1);
    @(negedge clk); check("tk_wr", 32'(wr_stb), 32'h1); check("tk_dt3", 32'(dtack_n), 32'h0);
    release_bus();
    @(negedge clk);

    // CRTC and TILEMAP reads
    start(24'h801234, 1'b1, 2'b00);
    repeat (5) @(negedge clk);
    release_bus();
    @(negedge clk);
    start(24'h900002, 1'b1, 2'b01);
    repeat (5) @(negedge clk);
    release_bus();
    @(negedge clk);

    // reset in the middle of a ROM write
    start(24'h000000, 1'b0, 2'b00);
    @(negedge clk);
    reset_n = 1'b0; release_bus();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_dt", 32'(dtack_n), 32'h1);

    // sources already high at reset release raise nothing
    reset_n = 1'b0; irq_src = 3'b111;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("hi_at_rst", 32'(ipl_n), 32'h7);
    irq_src = 3'b000;
    @(negedge clk);
    irq_src = 3'b010;
    @(negedge clk); check("irq1", 32'(ipl_n), 32'h5);
    irq_src = 3'b000;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

Interface
REQ-001 Parameter WAIT_ROM, default 1, wait cycles inserted before DTACK for ROM accesses.
REQ-002 Parameter WAIT_RAM, default 0, wait cycles for RAM accesses.
REQ-003 Parameter WAIT_IO, default 2, wait cycles for TICKS/CRTC/TILEMAP/PAL accesses.
REQ-004 Parameter TIMEOUT, default 255, cycles before BERR on an unmapped access.
REQ-005 The block SHALL have exactly one clock, clk, and its reset SHALL be synchronous and active-low.
REQ-006 clk  in  1  system clock; all state updates on rising edge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 as_n, rw  in  1 each  68000 address strobe and read/write (1 = read).
REQ-009 ds_n  in  2  data strobes {UDS_n, LDS_n}; fc  in  3  function code; addr  in  24  byte address.
REQ-010 irq_src  in  3  interrupt sources; bit n requests level n+1.
REQ-011 sel  out  6  one-hot region select {PAL, TILEMAP, CRTC, TICKS, RAM, ROM}.
REQ-012 wr_stb  out  2  single-cycle byte write strobes {upper, lower}.
REQ-013 dtack_n, vpa_n, berr_n  out  1 each  bus terminations, active-low.
REQ-014 ipl_n  out  3  active-low encoded interrupt priority level to CPU.

Function
REQ-015 Decode on addr[23:16]: 0x00 ROM, 0x10 RAM, 0x20 TICKS, 0x80 CRTC, 0x90 TILEMAP, 0x91 PAL; any other value unmapped.
REQ-016 FSM states IDLE, WAIT, ACK, HOLD; all outputs registered.
REQ-017 IDLE -> WAIT when as_n=0 and at least one ds_n bit is 0; sel is latched and the wait counter is loaded from the region parameter, or TIMEOUT if unmapped.
REQ-018 If fc=3'b111 in IDLE with as_n=0, the FSM SHALL go directly to ACK and drive vpa_n=0 (autovector); sel stays 0.
REQ-019 WAIT decrements the counter each cycle; at 0 a mapped access enters ACK with dtack_n=0, and an unmapped access enters ACK with berr_n=0.
REQ-020 A mapped access with wait count W SHALL assert dtack_n exactly W+1 cycles after the cycle IDLE sampled the strobe.
REQ-021 On entry to ACK for a mapped write (rw=0), wr_stb SHALL equal ~ds_n for exactly one cycle; wr_stb SHALL never assert for reads, IACK, or unmapped accesses.
REQ-022 ACK -> HOLD on the next cycle; termination outputs stay asserted in HOLD until as_n=1.
REQ-023 When as_n=1 in any non-IDLE state, the FSM SHALL return to IDLE and deassert dtack_n, vpa_n, berr_n and sel on the next cycle; an abort in WAIT produces no wr_stb.
REQ-024 A rising edge on irq_src[n] SHALL set pending[n]; ipl_n = ~(index of the highest set pending bit + 1), or 3'b111 if none; bit 2 has the highest priority.
REQ-025 An IACK cycle (fc=3'b111) entering ACK SHALL clear pending[addr[3:1]-1]; if a new edge on the same bit occurs in that cycle, the set SHALL win.
REQ-026 ipl_n SHALL reflect pending changes one cycle after the edge or the ack.

Reset
REQ-027 With reset_n=0: state IDLE, sel=0, wr_stb=0, dtack_n=vpa_n=berr_n=1, ipl_n=3'b111, pending=0, counter=0.
REQ-028 The irq edge-detect history SHALL reset to 3'b111, so sources already high at reset release raise no interrupt.
REQ-029 A reset asserted mid-cycle SHALL abandon the access; no wr_stb issues afterwards.

Structure
REQ-030 Package cpu_bus_pkg SHALL hold the region enum, the region base-byte constants, and the FSM state enum.
REQ-031 Edge detection, pending flags and the priority encoder SHALL form sub-module irq_prio.

Verification
REQ-032 ROM read at 0x000100 with WAIT_ROM=1 -> sel=6'b000001, dtack_n low 2 cycles after the strobe, released 1 cycle after as_n rises.
REQ-033 RAM word write at 0x100010, ds_n=2'b00 -> wr_stb=2'b11 for one cycle, dtack_n low 1 cycle after the strobe.
REQ-034 Read at 0x400000 (unmapped) -> berr_n low after 256 cycles, no dtack_n, no wr_stb.
REQ-035 Pulse irq_src[0], then irq_src[2] -> ipl_n goes 3'b110, then 3'b100; IACK with addr[3:1]=3 -> vpa_n=0 and ipl_n returns to 3'b110.
REQ-036 PAL write with as_n raised during WAIT (WAIT_IO=2) -> IDLE next cycle, wr_stb never asserted, dtack_n stays 1.
